// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares the single execute-stage ALU between the integer issue path
//   (requester 0) and the branch/address-generation path (requester 1).
//   The granted requester's operands/control drive the ALU combinationally;
//   the ALU result is captured into one response slot tagged with the
//   requester id. Valid/ready backpressure on both sides.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready           requester handshake (N = 0,1)
//   reqN_a/b/ctrl              requester operands and opaque ALU control
//   alu_a/alu_b/alu_ctrl       drive to ALU (zero when nothing granted)
//   alu_result/alu_zero        combinational ALU outputs
//   rsp_valid/ready            response handshake
//   rsp_id/result/zero         registered response contents
//   grant0_cnt/grant1_cnt      saturating accepted-operation counters

module alu_share_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt_q <= '0;
    else if (inc_i && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [CNT_W-1:0]  grant0_cnt,
  output logic [CNT_W-1:0]  grant1_cnt
);
  localparam int NREQ = 2;

  logic [NREQ-1:0]             vld, gnt;
  logic [NREQ-1:0][DATA_W-1:0] op_a, op_b;
  logic [NREQ-1:0][CTRL_W-1:0] op_c;
  logic [NREQ-1:0][CNT_W-1:0]  cnt;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              slot_free, xfer, sel;

  assign vld  = {req1_valid, req0_valid};
  assign op_a = {req1_a, req0_a};
  assign op_b = {req1_b, req0_b};
  assign op_c = {req1_ctrl, req0_ctrl};

  // Slot can take a new op when empty or being drained this same cycle.
  assign slot_free = !rsp_valid_q || rsp_ready;

  // rst_n gates the grant so ready stays low for the whole reset window.
  always_comb begin
    gnt = '0;
    if (rst_n && slot_free) begin
      if (&vld) gnt[rr_ptr_q] = 1'b1;
      else      gnt = vld;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign xfer       = |gnt;   // a grant is only ever issued to a valid requester
  assign sel        = gnt[1];

  assign alu_a    = xfer ? op_a[sel] : '0;
  assign alu_b    = xfer ? op_b[sel] : '0;
  assign alu_ctrl = xfer ? op_c[sel] : '0;

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    // The winner always hands priority to the other side, so a loser under
    // contention is served next and neither requester starves.
    rr_ptr_d     = rr_ptr_q;
    if (xfer) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = sel;
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_zero;
      rr_ptr_d     = ~sel;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rr_ptr_q     <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

  for (genvar n = 0; n < NREQ; n++) begin : g_req
    alu_share_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (gnt[n]),
      .cnt_o (cnt[n])
    );

    // Requester protocol: a pending op stays presented and unchanged.
    a_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (vld[n] && !gnt[n]) |=> (vld[n] && $stable(op_a[n]) &&
                                $stable(op_b[n]) && $stable(op_c[n])))
      else $error("requester %0d changed a pending op", n);
  end

  assign grant0_cnt = cnt[0];
  assign grant1_cnt = cnt[1];
endmodule
